gpio_pad_ctrl: RTL and testbench

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

---
 rtl/gpio_pad_pkg.sv | 62 ++++++
 rtl/gpio_sync2.sv | 29 ++
 rtl/gpio_pad_ctrl.sv | 151 +++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_pkg.sv
// Shared types and constants for the gpiov2 pad controller:
// the config word layout, the sequencing FSM states and the DM encodings.
package gpio_pad_pkg;

   localparam int CFG_W = 13;

   localparam int CFG_DM_LSB      = 0;
   localparam int CFG_INP_DIS     = 3;
   localparam int CFG_IB_MODE_SEL = 4;
   localparam int CFG_VTRIP_SEL   = 5;
   localparam int CFG_SLOW        = 6;
   localparam int CFG_HLD_OVR     = 7;
   localparam int CFG_ANALOG_EN   = 8;
   localparam int CFG_ANALOG_SEL  = 9;
   localparam int CFG_ANALOG_POL  = 10;
   localparam int CFG_OE_OVR_EN   = 11;
   localparam int CFG_OE_OVR_VAL  = 12;

   localparam logic [2:0] DM_INPUT  = 3'b001;
   localparam logic [2:0] DM_STRONG = 3'b110;

   typedef struct packed {
      logic       oe_ovr_val;
      logic       oe_ovr_en;
      logic       analog_pol;
      logic       analog_sel;
      logic       analog_en;
      logic       hld_ovr;
      logic       slow;
      logic       vtrip_sel;
      logic       ib_mode_sel;
      logic       inp_dis;
      logic [2:0] dm;
   } cfg_t;

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      ENABLE   = 3'd1,
      RELEASE  = 3'd2,
      RUN      = 3'd3,
      HOLD_ON  = 3'd4,
      APPLY    = 3'd5,
      HOLD_OFF = 3'd6
   } state_t;

   function automatic cfg_t cfg_from_word(input logic [CFG_W-1:0] w);
      cfg_t c;
      c.dm          = w[CFG_DM_LSB +: 3];
      c.inp_dis     = w[CFG_INP_DIS];
      c.ib_mode_sel = w[CFG_IB_MODE_SEL];
      c.vtrip_sel   = w[CFG_VTRIP_SEL];
      c.slow        = w[CFG_SLOW];
      c.hld_ovr     = w[CFG_HLD_OVR];
      c.analog_en   = w[CFG_ANALOG_EN];
      c.analog_sel  = w[CFG_ANALOG_SEL];
      c.analog_pol  = w[CFG_ANALOG_POL];
      c.oe_ovr_en   = w[CFG_OE_OVR_EN];
      c.oe_ovr_val  = w[CFG_OE_OVR_VAL];
      return c;
   endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer bringing the asynchronous pad input into the clk domain.
module gpio_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpiov2 pad controller: power-up sequencing, serially loaded shadow config,
// hold-protected config updates and registered core-side data paths.
module gpio_pad_ctrl
   import gpio_pad_pkg::*;
#(
   parameter logic [CFG_W-1:0] CFG_DEFAULT  = {10'd0, DM_INPUT},
   parameter int unsigned      PWRUP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_shift_en,
   input  logic       cfg_serial_in,
   output logic       cfg_serial_out,
   input  logic       cfg_load,
   input  logic       core_out,
   input  logic       core_oe,
   output logic       core_in,
   output logic       busy,
   output logic       pad_out,
   output logic       pad_oe_n,
   output logic       pad_hld_h_n,
   output logic       pad_enable_h,
   output logic       pad_enable_inp_h,
   output logic [2:0] pad_dm,
   output logic       pad_inp_dis,
   output logic       pad_ib_mode_sel,
   output logic       pad_vtrip_sel,
   output logic       pad_slow,
   output logic       pad_hld_ovr,
   output logic       pad_analog_en,
   output logic       pad_analog_sel,
   output logic       pad_analog_pol,
   input  logic       pad_in
);

   localparam logic [7:0] PWRUP_LAST = 8'(PWRUP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [CFG_W-1:0] shadow_q, shadow_d;
   cfg_t             active_q, active_d;
   logic             pad_out_q, pad_out_d;
   logic             oe_n_q, oe_n_d;
   logic             operating;
   logic             sync_in;

   always_comb begin
      shadow_d = shadow_q;
      if (cfg_shift_en) begin
         shadow_d = {shadow_q[CFG_W-2:0], cfg_serial_in};
      end
   end

   // Active config is loaded on entry to APPLY from the shadow value APPLY will
   // see, so pad pins switch while hold is asserted and a shift in the same
   // cycle is included.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == PWRUP_LAST) begin
               state_d = ENABLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ENABLE:   state_d = RELEASE;
         RELEASE:  state_d = RUN;
         RUN: begin
            if (cfg_load) begin
               state_d = HOLD_ON;
            end
         end
         HOLD_ON: begin
            state_d  = APPLY;
            active_d = cfg_from_word(shadow_d);
         end
         APPLY:    state_d = HOLD_OFF;
         HOLD_OFF: state_d = RUN;
         default:  state_d = PWR_WAIT;
      endcase
   end

   always_comb begin
      pad_enable_h     = 1'b1;
      pad_enable_inp_h = 1'b1;
      pad_hld_h_n      = 1'b1;
      case (state_q)
         PWR_WAIT: begin
            pad_enable_h     = 1'b0;
            pad_enable_inp_h = 1'b0;
            pad_hld_h_n      = 1'b0;
         end
         ENABLE, HOLD_ON, APPLY: pad_hld_h_n = 1'b0;
         default: ;
      endcase
   end

   always_comb begin
      operating = (state_q == RUN) || (state_q == HOLD_ON) ||
                  (state_q == APPLY) || (state_q == HOLD_OFF);
      pad_out_d = core_out;
      oe_n_d    = 1'b1;
      if (operating) begin
         oe_n_d = active_q.oe_ovr_en ? ~active_q.oe_ovr_val : ~core_oe;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= PWR_WAIT;
         cnt_q     <= 8'd0;
         shadow_q  <= '0;
         active_q  <= cfg_from_word(CFG_DEFAULT);
         pad_out_q <= 1'b0;
         oe_n_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pad_out_q <= pad_out_d;
         oe_n_q    <= oe_n_d;
      end
   end

   gpio_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_in),
      .q     (sync_in)
   );

   assign core_in         = sync_in & ~(active_q.inp_dis | active_q.analog_en);
   assign busy            = (state_q != RUN);
   assign cfg_serial_out  = shadow_q[CFG_W-1];
   assign pad_out         = pad_out_q;
   assign pad_oe_n        = oe_n_q;
   assign pad_dm          = active_q.dm;
   assign pad_inp_dis     = active_q.inp_dis;
   assign pad_ib_mode_sel = active_q.ib_mode_sel;
   assign pad_vtrip_sel   = active_q.vtrip_sel;
   assign pad_slow        = active_q.slow;
   assign pad_hld_ovr     = active_q.hld_ovr;
   assign pad_analog_en   = active_q.analog_en;
   assign pad_analog_sel  = active_q.analog_sel;
   assign pad_analog_pol  = active_q.analog_pol;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: a cycle-level behavioural model
// checked every clock, plus directed scenarios with literal expectations.
module tb_gpio_pad_ctrl;

   localparam int          P       = 4;
   localparam logic [12:0] CFG_DEF = 13'h0001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_shift_en, cfg_serial_in, cfg_load;
   logic       core_out, core_oe, pad_in;
   logic       cfg_serial_out, core_in, busy;
   logic       pad_out, pad_oe_n, pad_hld_h_n, pad_enable_h, pad_enable_inp_h;
   logic [2:0] pad_dm;
   logic       pad_inp_dis, pad_ib_mode_sel, pad_vtrip_sel, pad_slow, pad_hld_ovr;
   logic       pad_analog_en, pad_analog_sel, pad_analog_pol;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   gpio_pad_ctrl #(
      .CFG_DEFAULT  (CFG_DEF),
      .PWRUP_CYCLES (P)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg_shift_en     (cfg_shift_en),
      .cfg_serial_in    (cfg_serial_in),
      .cfg_serial_out   (cfg_serial_out),
      .cfg_load         (cfg_load),
      .core_out         (core_out),
      .core_oe          (core_oe),
      .core_in          (core_in),
      .busy             (busy),
      .pad_out          (pad_out),
      .pad_oe_n         (pad_oe_n),
      .pad_hld_h_n      (pad_hld_h_n),
      .pad_enable_h     (pad_enable_h),
      .pad_enable_inp_h (pad_enable_inp_h),
      .pad_dm           (pad_dm),
      .pad_inp_dis      (pad_inp_dis),
      .pad_ib_mode_sel  (pad_ib_mode_sel),
      .pad_vtrip_sel    (pad_vtrip_sel),
      .pad_slow         (pad_slow),
      .pad_hld_ovr      (pad_hld_ovr),
      .pad_analog_en    (pad_analog_en),
      .pad_analog_sel   (pad_analog_sel),
      .pad_analog_pol   (pad_analog_pol),
      .pad_in           (pad_in)
   );

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time since reset decides the power-up phase, mUpd counts cycles
   // into an update (-1 when none in progress).
   int          mSince = 0;
   int          mUpd   = -1;
   logic [12:0] mShadow, mActive;
   logic        mS1, mS2, mOut, mOeN;
   logic        mValid = 1'b0;

   always @(posedge clk) begin
      logic opOld, runOld;
      logic eBusy, eEn, eHld, eCin;
      if (!rst_n) begin
         mSince  = 0;
         mUpd    = -1;
         mShadow = 13'h0;
         mActive = CFG_DEF;
         mS1     = 1'b0;
         mS2     = 1'b0;
         mOut    = 1'b0;
         mOeN    = 1'b1;
         mValid  = 1'b1;
      end else if (mValid) begin
         opOld  = (mSince >= P + 2);
         runOld = opOld && (mUpd < 0);
         mOeN   = opOld ? (mActive[11] ? !mActive[12] : !core_oe) : 1'b1;
         if (mUpd >= 0) mUpd = (mUpd == 2) ? -1 : mUpd + 1;
         else if (runOld && cfg_load) mUpd = 0;
         if (cfg_shift_en) mShadow = {mShadow[11:0], cfg_serial_in};
         if (mUpd == 1) mActive = mShadow;
         if (mSince < P + 2) mSince++;
         mS2  = mS1;
         mS1  = pad_in;
         mOut = core_out;
      end
      #2;
      if (mValid) begin
         eBusy = !((mSince >= P + 2) && (mUpd < 0));
         eEn   = (mSince >= P);
         eHld  = (mSince >= P + 1) && !(mUpd == 0 || mUpd == 1);
         eCin  = mS2 && !mActive[3] && !mActive[8];
         checkOutput("m_busy", 16'(busy), 16'(eBusy));
         checkOutput("m_enable_h", 16'(pad_enable_h), 16'(eEn));
         checkOutput("m_enable_inp_h", 16'(pad_enable_inp_h), 16'(eEn));
         checkOutput("m_hld_h_n", 16'(pad_hld_h_n), 16'(eHld));
         checkOutput("m_oe_n", 16'(pad_oe_n), 16'(mOeN));
         checkOutput("m_pad_out", 16'(pad_out), 16'(mOut));
         checkOutput("m_core_in", 16'(core_in), 16'(eCin));
         checkOutput("m_serial_out", 16'(cfg_serial_out), 16'(mShadow[12]));
         checkOutput("m_dm", 16'(pad_dm), 16'(mActive[2:0]));
         checkOutput("m_static_pins",
                     16'({pad_analog_pol, pad_analog_sel, pad_analog_en, pad_hld_ovr,
                          pad_slow, pad_vtrip_sel, pad_ib_mode_sel, pad_inp_dis}),
                     16'(mActive[10:3]));
      end
   end

   task automatic applyStimulus(input logic sh, input logic sin, input logic ld);
      cfg_shift_en  = sh;
      cfg_serial_in = sin;
      cfg_load      = ld;
      @(negedge clk);
      cfg_shift_en  = 1'b0;
      cfg_serial_in = 1'b0;
      cfg_load      = 1'b0;
   endtask

   task automatic shiftWord(input logic [12:0] w, input logic loadLast);
      for (int i = 12; i >= 0; i--) begin
         core_out = ~core_out;
         applyStimulus(1'b1, w[i], loadLast && (i == 0));
      end
   endtask

   initial begin
      logic [12:0] word;
      rst_n = 1'b0;
      cfg_shift_en = 1'b0; cfg_serial_in = 1'b0; cfg_load = 1'b0;
      core_out = 1'b0; core_oe = 1'b0; pad_in = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("rst_busy", 16'(busy), 16'd1);
      checkOutput("rst_hld", 16'(pad_hld_h_n), 16'd0);
      checkOutput("rst_en", 16'(pad_enable_h), 16'd0);
      checkOutput("rst_oe_n", 16'(pad_oe_n), 16'd1);
      checkOutput("rst_dm", 16'(pad_dm), 16'd1);

      // Power-up, with a cfg_load that must be ignored during PWR_WAIT
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("pwr_en_c1", 16'(pad_enable_h), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pwr_en_c3", 16'(pad_enable_h), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pwr_en_c4", 16'(pad_enable_h), 16'd1);
      checkOutput("pwr_hld_c4", 16'(pad_hld_h_n), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pwr_hld_c5", 16'(pad_hld_h_n), 16'd1);
      checkOutput("pwr_busy_c5", 16'(busy), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pwr_busy_c6", 16'(busy), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pwr_no_hold", 16'(pad_hld_h_n), 16'd1);
      checkOutput("pwr_dm", 16'(pad_dm), 16'd1);

      // Serial load of a strong-drive, slow-slew config
      word = 13'h1046;
      for (int i = 12; i >= 0; i--) begin
         core_out = i[0];
         applyStimulus(1'b1, word[i], 1'b0);
         if (i == 1) checkOutput("ser_out_pre", 16'(cfg_serial_out), 16'd0);
      end
      checkOutput("ser_out_msb", 16'(cfg_serial_out), 16'd1);
      checkOutput("dm_after_shift", 16'(pad_dm), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("upd_hold_on", 16'(pad_hld_h_n), 16'd0);
      checkOutput("upd_dm_hold_on", 16'(pad_dm), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("upd_apply_hld", 16'(pad_hld_h_n), 16'd0);
      checkOutput("upd_apply_dm", 16'(pad_dm), 16'd6);
      checkOutput("upd_apply_slow", 16'(pad_slow), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("upd_hold_off", 16'(pad_hld_h_n), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("upd_run_busy", 16'(busy), 16'd0);

      // Output-enable override, loaded with a shift in the load cycle
      core_oe = 1'b1;
      shiftWord(13'h0806, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("oe_ovr_forced", 16'(pad_oe_n), 16'd1);
      shiftWord(13'h0006, 1'b1);
      checkOutput("oe_clr_hold_on", 16'(pad_oe_n), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("oe_clr_apply", 16'(pad_oe_n), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("oe_clr_hold_off", 16'(pad_oe_n), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      core_oe = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("oe_core_off", 16'(pad_oe_n), 16'd1);

      // Input synchronizer latency and input-disable gating
      pad_in = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("cin_lat1", 16'(core_in), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("cin_rise", 16'(core_in), 16'd1);
      pad_in = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("cin_fall_lat1", 16'(core_in), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("cin_fall", 16'(core_in), 16'd0);
      pad_in = 1'b1;
      shiftWord(13'h000E, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("cin_inp_dis", 16'(core_in), 16'd0);
      shiftWord(13'h0106, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("cin_analog", 16'(core_in), 16'd0);
      shiftWord(13'h0006, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("cin_reenabled", 16'(core_in), 16'd1);

      // Reset landing in the middle of an update
      shiftWord(13'h1046, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("mid_apply_dm", 16'(pad_dm), 16'd6);
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("mid_rst_hld", 16'(pad_hld_h_n), 16'd0);
      checkOutput("mid_rst_dm", 16'(pad_dm), 16'd1);
      checkOutput("mid_rst_slow", 16'(pad_slow), 16'd0);
      checkOutput("mid_rst_busy", 16'(busy), 16'd1);
      checkOutput("mid_rst_core_in", 16'(core_in), 16'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         core_out = i[0];
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
      checkOutput("final_busy", 16'(busy), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule
